// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg: constants and types shared by the fetch stage and the register
// blocks that sit downstream of it.
//   DATA_W        : instruction word width (matches the IR)
//   ADDR_W        : program counter / memory address width
//   fetch_state_t : fetch sequencer states
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        LOAD = 3'd3,
        HOLD = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_mem_if: instruction memory read port.
//   mem_req    : read request, held until granted
//   mem_addr   : read address, meaningful while mem_req is high
//   mem_gnt    : memory accepts the request in this cycle
//   mem_rvalid : mem_rdata carries the read word in this cycle
//   mem_rdata  : read word
// Handshake: a request is transferred on the cycle where mem_req and mem_gnt
// are both high; the requester keeps mem_req and mem_addr stable until then.
// Exactly one mem_rvalid pulse answers each transferred request, at any later
// cycle. Only one request is ever outstanding.
// Modports: master = fetch unit, slave = memory.
// -----------------------------------------------------------------------------
interface fetch_mem_if import cpu_pkg::*; ();

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );

endinterface

// File: rtl/fetch_unit_pc_counter.sv
// -----------------------------------------------------------------------------
// pc_counter: program counter register.
//   i_clk, i_rst_n : clock, asynchronous active-low reset (PC <= RESET_PC)
//   i_set          : load i_set_val (branch target)
//   i_set_val      : value to load
//   i_inc          : increment by one, wrapping modulo 2^ADDR_W
//   o_pc           : current PC
// Set has priority over increment; the fetch FSM never asserts both.
// -----------------------------------------------------------------------------
module pc_counter import cpu_pkg::*; #(
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_set,
    input  logic [ADDR_W-1:0] i_set_val,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_pc
);

    logic [ADDR_W-1:0] r_pc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc <= RESET_PC;
        end else if (i_set) begin
            r_pc <= i_set_val;
        end else if (i_inc) begin
            r_pc <= r_pc + ADDR_W'(1);
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit: instruction fetch stage feeding the 16-bit instruction register.
// Reads one word per fetch over the req/gnt + rvalid port, presents it to the
// IR as a one-cycle load strobe, advances the PC and then holds for the core.
// Ports:
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_start          : leave IDLE and fetch at the current PC
//   i_halt           : go IDLE once the fetch in flight completes
//   i_next           : core consumed the IR; fetch the next word
//   i_branch         : load PC from i_branch_addr (IDLE / HOLD only)
//   i_branch_addr    : branch target
//   mem              : memory read port (fetch_mem_if.master)
//   o_ir_load        : one-cycle IR load strobe
//   o_ir_data        : IR word, valid with o_ir_load (0 otherwise)
//   o_pc             : current PC
//   o_busy           : high in every state but IDLE
//   o_fetch_err      : one-cycle watchdog pulse
//   o_state          : FSM state, for observation
// Build option FETCH_TIMEOUT_EN: adds a WAIT-state watchdog of TIMEOUT_CYCLES
// cycles; without it WAIT waits forever and o_fetch_err is tied low.
// -----------------------------------------------------------------------------
module fetch_unit import cpu_pkg::*; #(
    parameter logic [ADDR_W-1:0] RESET_PC = '0
`ifdef FETCH_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_halt,
    input  logic              i_next,
    input  logic              i_branch,
    input  logic [ADDR_W-1:0] i_branch_addr,
    fetch_mem_if.master       mem,
    output logic              o_ir_load,
    output logic [DATA_W-1:0] o_ir_data,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_busy,
    output logic              o_fetch_err,
    output fetch_state_t      o_state
);

    fetch_state_t      r_state;
    fetch_state_t      w_next_state;
    logic [DATA_W-1:0] r_buf;
    logic              r_halt_pend;
    logic              w_pc_set;
    logic              w_pc_inc;
    logic              w_halt;
    logic              w_timeout;
    logic [ADDR_W-1:0] w_pc;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] r_wait_cnt;

    // Counts cycles spent in WAIT; any other state clears it, so it is zero
    // on every entry to WAIT.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wait_cnt <= '0;
        end else if (r_state == WAIT) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end else begin
            r_wait_cnt <= '0;
        end
    end

    assign w_timeout = (r_state == WAIT) && !mem.mem_rvalid && (r_wait_cnt == CNT_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    // A halt requested while a fetch is in flight is remembered and honoured
    // at the next HOLD; leaving the in-flight states drops it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_halt_pend <= 1'b0;
        end else if (r_state == REQ || r_state == WAIT || r_state == LOAD) begin
            r_halt_pend <= r_halt_pend | i_halt;
        end else begin
            r_halt_pend <= 1'b0;
        end
    end

    assign w_halt = i_halt | r_halt_pend;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_buf   <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == WAIT && mem.mem_rvalid) begin
                r_buf <= mem.mem_rdata;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pc_set     = 1'b0;
        w_pc_inc     = 1'b0;
        case (r_state)
            IDLE: begin
                w_pc_set = i_branch;
                if (i_start) begin
                    w_next_state = REQ;
                end
            end
            REQ: begin
                if (mem.mem_gnt) begin
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                if (mem.mem_rvalid) begin
                    w_next_state = LOAD;
                end else if (w_timeout) begin
                    w_next_state = IDLE;
                end
            end
            LOAD: begin
                w_pc_inc     = 1'b1;
                w_next_state = HOLD;
            end
            HOLD: begin
                // Halt beats branch beats next; branch+next fetches the target.
                if (w_halt) begin
                    w_next_state = IDLE;
                end else if (i_branch) begin
                    w_pc_set     = 1'b1;
                    w_next_state = REQ;
                end else if (i_next) begin
                    w_next_state = REQ;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    pc_counter #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_set     (w_pc_set),
        .i_set_val (i_branch_addr),
        .i_inc     (w_pc_inc),
        .o_pc      (w_pc)
    );

    assign mem.mem_req  = (r_state == REQ);
    assign mem.mem_addr = (r_state == REQ) ? w_pc : '0;
    assign o_ir_load    = (r_state == LOAD);
    assign o_ir_data    = (r_state == LOAD) ? r_buf : '0;
    assign o_pc         = w_pc;
    assign o_busy       = (r_state != IDLE);
    assign o_fetch_err  = w_timeout;
    assign o_state      = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit: directed bench for fetch_unit. The bench plays the memory,
// keeps its own PC and expected IR words, and a compare process checks the
// DUT against them on every falling clock edge.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
    import cpu_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              halt = 1'b0;
    logic              nxt = 1'b0;
    logic              branch = 1'b0;
    logic [ADDR_W-1:0] branch_addr = '0;
    logic              ir_load;
    logic [DATA_W-1:0] ir_data;
    logic [ADDR_W-1:0] pc_out;
    logic              busy;
    logic              fetch_err;
    fetch_state_t      dbg_state;

    fetch_mem_if mem_bus ();

    fetch_unit dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_halt        (halt),
        .i_next        (nxt),
        .i_branch      (branch),
        .i_branch_addr (branch_addr),
        .mem           (mem_bus),
        .o_ir_load     (ir_load),
        .o_ir_data     (ir_data),
        .o_pc          (pc_out),
        .o_busy        (busy),
        .o_fetch_err   (fetch_err),
        .o_state       (dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // model state
    int                n_cmp = 0;
    int                n_fail = 0;
    int                n_loads = 0;
    logic              chk_en = 1'b0;
    logic [ADDR_W-1:0] model_pc = '0;
    logic              br_pend = 1'b0;
    logic [ADDR_W-1:0] br_target = '0;
    logic [DATA_W-1:0] last_data = '0;
    logic [DATA_W-1:0] exp_q[$];
    int                exp_cyc_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: the PC the core should see, the address of any request,
    // and the IR words, each one cycle after the memory returned it.
    always @(negedge clk) begin
        if (chk_en) begin
            check("pc_out", pc_out, model_pc);
`ifndef FETCH_TIMEOUT_EN
            check("fetch_err_tied", fetch_err, 0);
`endif
            if (mem_bus.mem_req) check("mem_addr", mem_bus.mem_addr, model_pc);
            if (exp_q.size() > 0 && exp_cyc_q[0] == cyc) begin
                check("ir_load", ir_load, 1);
                check("ir_data", ir_data, exp_q[0]);
                void'(exp_q.pop_front());
                void'(exp_cyc_q.pop_front());
                last_data = ir_data;
                n_loads++;
                model_pc = model_pc + 1'b1;
            end else begin
                check("ir_load_idle", ir_load, 0);
                if (ir_load) n_loads++;
            end
            if (br_pend) begin
                model_pc = br_target;
                br_pend  = 1'b0;
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_go(input logic br, input logic [ADDR_W-1:0] addr);
        start = 1'b1;
        branch = br;
        branch_addr = addr;
        if (br) begin
            br_pend = 1'b1;
            br_target = addr;
        end
        step();
        start = 1'b0;
        branch = 1'b0;
    endtask

    task automatic hold_go(input logic n, input logic br, input logic [ADDR_W-1:0] addr);
        nxt = n;
        branch = br;
        branch_addr = addr;
        if (br) begin
            br_pend = 1'b1;
            br_target = addr;
        end
        step();
        nxt = 1'b0;
        branch = 1'b0;
    endtask

    // Entered with the DUT in REQ; returns with it in HOLD.
    // wact: 1 = branch in first WAIT cycle, 2 = halt in first WAIT cycle.
    task automatic fetch_one(input int gdly, input int rdly, input logic [DATA_W-1:0] data,
                             input int wact);
        for (int i = 0; i < gdly; i++) begin
            check("req_held", mem_bus.mem_req, 1);
            check("addr_held", mem_bus.mem_addr, model_pc);
            if (i == 0) begin
                mem_bus.mem_rvalid = 1'b1;
                mem_bus.mem_rdata  = 16'hDEAD;
            end
            step();
            mem_bus.mem_rvalid = 1'b0;
        end
        mem_bus.mem_gnt = 1'b1;
        step();
        mem_bus.mem_gnt = 1'b0;
        for (int i = 0; i < rdly; i++) begin
            if (i == 0 && wact == 1) begin
                branch = 1'b1;
                branch_addr = 16'h1234;
            end
            if (i == 0 && wact == 2) halt = 1'b1;
            step();
            branch = 1'b0;
            halt = 1'b0;
        end
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata  = data;
        exp_q.push_back(data);
        exp_cyc_q.push_back(cyc + 1);
        step();
        mem_bus.mem_rvalid = 1'b0;
        step();
    endtask

    initial begin
        int nl;
        int errs;
        mem_bus.mem_gnt = 1'b0;
        mem_bus.mem_rvalid = 1'b0;
        mem_bus.mem_rdata = '0;

        // reset values
        step();
        step();
        check("rst_req", mem_bus.mem_req, 0);
        check("rst_addr", mem_bus.mem_addr, 0);
        check("rst_load", ir_load, 0);
        check("rst_data", ir_data, 0);
        check("rst_busy", busy, 0);
        check("rst_err", fetch_err, 0);
        check("rst_pc", pc_out, 16'h0000);
        rst_n = 1'b1;
        model_pc = 16'h0000;
        chk_en = 1'b1;
        step();

        // 1: immediate grant, data one cycle later
        start_go(1'b0, '0);
        check("t1_addr", mem_bus.mem_addr, 16'h0000);
        check("t1_busy", busy, 1);
        fetch_one(0, 0, 16'h64C2, 0);
        check("t1_ir_data", last_data, 16'h64C2);
        check("t1_pc", pc_out, 16'h0001);

        // 2: grant withheld for three cycles, stray rvalid in REQ
        hold_go(1'b1, 1'b0, '0);
        fetch_one(3, 0, 16'h1A2B, 0);
        check("t2_pc", pc_out, 16'h0002);

        // branch during WAIT is ignored
        hold_go(1'b1, 1'b0, '0);
        fetch_one(0, 2, 16'h1357, 1);
        check("wait_br_pc", pc_out, 16'h0003);

        // 3: branch and next together in HOLD
        hold_go(1'b1, 1'b1, 16'h0040);
        check("t3_addr", mem_bus.mem_addr, 16'h0040);
        fetch_one(1, 1, 16'hC0DE, 0);

        // stray rvalid in HOLD
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata = 16'hBAD0;
        step();
        mem_bus.mem_rvalid = 1'b0;
        step();
        check("hold_busy", busy, 1);

        // 4: wrap from FFFF
        hold_go(1'b0, 1'b1, 16'hFFFF);
        check("t4_addr", mem_bus.mem_addr, 16'hFFFF);
        fetch_one(0, 0, 16'h7777, 0);
        check("t4_pc", pc_out, 16'h0000);

        // 5a: reset during WAIT, late rvalid ignored
        hold_go(1'b0, 1'b1, 16'h0123);
        mem_bus.mem_gnt = 1'b1;
        step();
        mem_bus.mem_gnt = 1'b0;
        step();
        rst_n = 1'b0;
        model_pc = 16'h0000;
        br_pend = 1'b0;
        exp_q.delete();
        exp_cyc_q.delete();
        #1;
        check("t5_rst_pc", pc_out, 16'h0000);
        check("t5_rst_busy", busy, 0);
        step();
        rst_n = 1'b1;
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata = 16'hBEEF;
        step();
        mem_bus.mem_rvalid = 1'b0;
        step();
        check("t5_busy", busy, 0);
        check("t5_req", mem_bus.mem_req, 0);
        check("t5_pc", pc_out, 16'h0000);

        // 5b: halt during WAIT -> one load, then IDLE
        start_go(1'b0, '0);
        nl = n_loads;
        fetch_one(0, 1, 16'hA5A5, 2);
        check("t5b_hold_busy", busy, 1);
        step();
        check("t5b_busy", busy, 0);
        check("t5b_req", mem_bus.mem_req, 0);
        step();
        step();
        check("t5b_idle_req", mem_bus.mem_req, 0);
        check("t5b_loads", n_loads - nl, 1);
        check("t5b_pc", pc_out, 16'h0001);

        // branch in IDLE together with start
        start_go(1'b1, 16'h0200);
        check("idle_br_addr", mem_bus.mem_addr, 16'h0200);
        fetch_one(1, 0, 16'h0F0F, 0);
        halt = 1'b1;
        step();
        halt = 1'b0;
        check("halt_hold_busy", busy, 0);
        check("halt_hold_pc", pc_out, 16'h0201);

`ifdef FETCH_TIMEOUT_EN
        // 6: watchdog in WAIT
        start_go(1'b0, '0);
        mem_bus.mem_gnt = 1'b1;
        step();
        mem_bus.mem_gnt = 1'b0;
        errs = 0;
        for (int i = 0; i < 70; i++) begin
            if (fetch_err) errs++;
            step();
        end
        check("t6_err_pulses", errs, 1);
        check("t6_busy", busy, 0);
        check("t6_pc", pc_out, 16'h0201);
`else
        errs = 0;
        check("no_timeout_err", fetch_err + errs, 0);
`endif

        step();
        check("exp_q_empty", exp_q.size(), 0);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // absolute time bound
    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
